// File: rtl/bcnt_pkg.sv
// Mode encoding shared by the bcnt_bank counter bank and its lanes.
package bcnt_pkg;

  typedef enum logic [1:0] {
    BCNT_SAT    = 2'd0,
    BCNT_ROLL   = 2'd1,
    BCNT_BOUNCE = 2'd2,
    BCNT_RSVD   = 2'd3
  } bcnt_mode_e;

  // The reserved encoding behaves exactly like saturation.
  function automatic bcnt_mode_e bcnt_mode_norm(input bcnt_mode_e m);
    return (m == BCNT_RSVD) ? BCNT_SAT : m;
  endfunction

endpackage

// File: rtl/bcnt_lane.sv
// One up/down counter channel: count register, bounce direction, event register.
// o_ovf_nxt is the pre-register event so a neighbour can tick on the same edge.
module bcnt_lane
  import bcnt_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] START_V = '0
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             i_srst,
  input  bcnt_mode_e       i_mode,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_lim,
  input  logic             i_ena,
  input  logic             i_dir,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic             o_at_lim,
  output logic             o_evt,
  output logic             o_ovf_nxt
);

  bcnt_mode_e       w_mode;
  logic             w_up;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_ovf_up;
  logic             w_ovf_dn;
  logic             w_at_lim;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_dir_nxt;
  logic             w_evt_nxt;
  logic [WIDTH-1:0] r_q;
  logic             r_dir_st;
  logic             r_evt;

  assign w_mode   = bcnt_mode_norm(i_mode);
  assign w_up     = (w_mode == BCNT_BOUNCE) ? r_dir_st : i_dir;
  assign w_sum    = {1'b0, r_q} + {1'b0, i_step};
  assign w_diff   = r_q - i_step;
  assign w_ovf_up = (w_sum > {1'b0, i_lim});
  assign w_ovf_dn = (r_q < i_step);
  assign w_at_lim = w_up ? (r_q == i_lim) : (r_q == '0);

  always_comb begin
    w_q_nxt   = r_q;
    w_dir_nxt = r_dir_st;
    w_evt_nxt = 1'b0;
    if (i_srst) begin
      w_q_nxt   = START_V;
      w_dir_nxt = 1'b1;
    end else if (i_load) begin
      w_q_nxt = i_load_val;
    end else if (i_ena) begin
      if ((w_mode == BCNT_BOUNCE) && w_at_lim) begin
        // Sitting on the bound: reverse and take the step in the new direction now.
        w_evt_nxt = 1'b1;
        w_dir_nxt = ~w_up;
        if (w_up) w_q_nxt = w_ovf_dn ? '0 : w_diff;
        else      w_q_nxt = w_ovf_up ? i_lim : w_sum[WIDTH-1:0];
      end else if (w_up) begin
        if (!w_ovf_up) begin
          w_q_nxt = w_sum[WIDTH-1:0];
        end else begin
          case (w_mode)
            BCNT_ROLL: begin
              w_q_nxt   = '0;
              w_evt_nxt = 1'b1;
            end
            BCNT_BOUNCE: begin
              w_q_nxt   = i_lim;
              w_dir_nxt = 1'b0;
              w_evt_nxt = 1'b1;
            end
            default: begin
              w_q_nxt   = i_lim;
              w_evt_nxt = (r_q != i_lim);
            end
          endcase
        end
      end else begin
        if (!w_ovf_dn) begin
          w_q_nxt = w_diff;
        end else begin
          case (w_mode)
            BCNT_ROLL: begin
              w_q_nxt   = i_lim;
              w_evt_nxt = 1'b1;
            end
            BCNT_BOUNCE: begin
              w_q_nxt   = '0;
              w_dir_nxt = 1'b1;
              w_evt_nxt = 1'b1;
            end
            default: begin
              w_q_nxt   = '0;
              w_evt_nxt = (r_q != '0);
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_q      <= START_V;
      r_dir_st <= 1'b1;
      r_evt    <= 1'b0;
    end else begin
      r_q      <= w_q_nxt;
      r_dir_st <= w_dir_nxt;
      r_evt    <= w_evt_nxt;
    end
  end

  assign o_q       = r_q;
  assign o_evt     = r_evt;
  assign o_at_lim  = w_at_lim;
  assign o_ovf_nxt = w_evt_nxt;

endmodule

// File: rtl/bcnt_bank.sv
// Bank of CH run-time programmable up/down counters with shared step, limit and mode.
// Define BCNT_BANK_CASCADE_EN to chain channel i's enable on channel i-1's same-edge event.
module bcnt_bank
  import bcnt_pkg::*;
#(
  parameter int CH    = 4,
  parameter int WIDTH = 8,
  parameter int START = 0
) (
  input  logic                      clk,
  input  logic                      aclr,
  input  logic                      srst,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          step,
  input  logic [WIDTH-1:0]          lim,
  input  logic [CH-1:0]             ena,
  input  logic [CH-1:0]             dir,
  input  logic [CH-1:0]             load,
  input  logic [CH-1:0][WIDTH-1:0]  load_val,
  output logic [CH-1:0][WIDTH-1:0]  q,
  output logic [CH-1:0]             at_lim,
  output logic [CH-1:0]             evt
);

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);

  if ((CH < 1) || (WIDTH < 2) || (START < 0) ||
      (longint'(START) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_param
    $error("bcnt_bank: illegal CH/WIDTH/START combination");
  end

  bcnt_mode_e    w_mode;
  logic [CH-1:0] w_ena;
  logic [CH-1:0] w_ovf;

  assign w_mode = bcnt_mode_e'(mode);

`ifdef BCNT_BANK_CASCADE_EN
  assign w_ena[0] = ena[0];
  for (genvar i = 1; i < CH; i++) begin : g_casc
    assign w_ena[i] = ena[i] & w_ovf[i-1];
  end
`else
  logic w_unused_ovf;
  assign w_ena        = ena;
  assign w_unused_ovf = ^w_ovf;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_lane
    bcnt_lane #(
      .WIDTH   (WIDTH),
      .START_V (START_V)
    ) u_lane (
      .clk        (clk),
      .aclr       (aclr),
      .i_srst     (srst),
      .i_mode     (w_mode),
      .i_step     (step),
      .i_lim      (lim),
      .i_ena      (w_ena[i]),
      .i_dir      (dir[i]),
      .i_load     (load[i]),
      .i_load_val (load_val[i]),
      .o_q        (q[i]),
      .o_at_lim   (at_lim[i]),
      .o_evt      (evt[i]),
      .o_ovf_nxt  (w_ovf[i])
    );
  end

endmodule

// File: tb/tb_bcnt_bank.sv
// Randomised and directed bench for bcnt_bank against an integer reference model.
`timescale 1ns/1ps
module tb_bcnt_bank;

  localparam int CH    = 4;
  localparam int WIDTH = 8;
  localparam int START = 3;

  logic                     clk = 1'b0;
  logic                     aclr;
  logic                     srst;
  logic [1:0]               mode;
  logic [WIDTH-1:0]         step;
  logic [WIDTH-1:0]         lim;
  logic [CH-1:0]            ena;
  logic [CH-1:0]            dir;
  logic [CH-1:0]            load;
  logic [CH-1:0][WIDTH-1:0] load_val;
  logic [CH-1:0][WIDTH-1:0] q;
  logic [CH-1:0]            at_lim;
  logic [CH-1:0]            evt;

  int n_chk = 0;
  int n_err = 0;
  int m_q[CH];
  bit m_ds[CH];
  bit m_evt[CH];

  always #5 clk = ~clk;

  bcnt_bank #(.CH(CH), .WIDTH(WIDTH), .START(START)) dut (
    .clk      (clk),
    .aclr     (aclr),
    .srst     (srst),
    .mode     (mode),
    .step     (step),
    .lim      (lim),
    .ena      (ena),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .at_lim   (at_lim),
    .evt      (evt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < CH; i++) begin
      m_q[i]   = START;
      m_ds[i]  = 1'b1;
      m_evt[i] = 1'b0;
    end
  endtask

  // Reference: one clock edge of every channel, in channel order so a cascade sees its neighbour.
  task automatic mdl_tick();
    int md;
    int s;
    int lm;
    bit pre;
    md  = (mode == 2'd3) ? 0 : int'(mode);
    s   = int'(step);
    lm  = int'(lim);
    pre = 1'b0;
    for (int i = 0; i < CH; i++) begin
      bit en;
      bit up;
      int v;
      en = ena[i];
`ifdef BCNT_BANK_CASCADE_EN
      if (i > 0) en = en && pre;
`endif
      v        = m_q[i];
      m_evt[i] = 1'b0;
      if (srst) begin
        m_q[i]  = START;
        m_ds[i] = 1'b1;
      end else if (load[i]) begin
        m_q[i] = int'(load_val[i]);
      end else if (en) begin
        up = (md == 2) ? m_ds[i] : dir[i];
        if (md == 2 && v == (up ? lm : 0)) begin
          m_evt[i] = 1'b1;
          m_ds[i]  = !up;
          if (up) m_q[i] = (v >= s) ? v - s : 0;
          else    m_q[i] = (s > lm) ? lm : s;
        end else if (up && v + s <= lm) begin
          m_q[i] = v + s;
        end else if (!up && v >= s) begin
          m_q[i] = v - s;
        end else begin
          case (md)
            1: begin
              m_q[i]   = up ? 0 : lm;
              m_evt[i] = 1'b1;
            end
            2: begin
              m_q[i]   = up ? lm : 0;
              m_ds[i]  = !up;
              m_evt[i] = 1'b1;
            end
            default: begin
              m_q[i]   = up ? lm : 0;
              m_evt[i] = (m_q[i] != v);
            end
          endcase
        end
      end
      pre = m_evt[i];
    end
  endtask

  task automatic cmp_all(input string ph);
    for (int i = 0; i < CH; i++) begin
      check($sformatf("%s q[%0d]", ph, i), 32'(q[i]), m_q[i]);
      check($sformatf("%s evt[%0d]", ph, i), 32'(evt[i]), 32'(m_evt[i]));
    end
  endtask

  task automatic cmp_lim(input string ph);
    int md;
    bit up;
    md = (mode == 2'd3) ? 0 : int'(mode);
    for (int i = 0; i < CH; i++) begin
      up = (md == 2) ? m_ds[i] : dir[i];
      check($sformatf("%s at_lim[%0d]", ph, i), 32'(at_lim[i]),
            32'(up ? (m_q[i] == int'(lim)) : (m_q[i] == 0)));
    end
  endtask

  task automatic cyc(input string ph);
    #1;
    cmp_lim(ph);
    @(posedge clk);
    mdl_tick();
    #1;
    cmp_all(ph);
  endtask

  task automatic set0(input bit en, input bit d, input bit ld, input int lv);
    ena[0]      = en;
    dir[0]      = d;
    load[0]     = ld;
    load_val[0] = WIDTH'(lv);
  endtask

  task automatic rnd_others();
    for (int i = 1; i < CH; i++) begin
      ena[i]      = 1'($urandom);
      dir[i]      = 1'($urandom);
      load[i]     = ($urandom_range(7) == 0);
      load_val[i] = WIDTH'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int sat_q[5]  = '{3, 6, 9, 10, 10};
    int sat_e[5]  = '{0, 0, 0, 1, 0};
    int roll_q[5] = '{1, 10, 6, 2, 10};
    int roll_e[5] = '{0, 1, 0, 0, 1};
    int bnc_q[7]  = '{2, 4, 5, 3, 1, 0, 2};
    int bnc_e[7]  = '{0, 0, 1, 0, 0, 1, 0};
    int rev_q[3]  = '{5, 4, 3};
    int rev_e[3]  = '{0, 1, 0};

    aclr = 1'b1; srst = 1'b0; mode = 2'd0; step = 8'd1; lim = 8'd200;
    ena = '0; dir = '1; load = '0; load_val = '0;
    mdl_reset();
    #12;
    cmp_all("reset");
    cmp_lim("reset");
    @(negedge clk);
    aclr = 1'b0;

    // Asynchronous clear in the middle of counting, then resume.
    for (int k = 0; k < 4; k++) begin
      set0(1, 1, 0, 0);
      rnd_others();
      cyc("count");
    end
    #2;
    aclr = 1'b1;
    #1;
    mdl_reset();
    cmp_all("aclr");
    check("aclr_q0_no_edge", 32'(q[0]), START);
    @(posedge clk);
    #1;
    check("aclr_q0_held", 32'(q[0]), START);
    @(negedge clk);
    aclr = 1'b0;
    load = '0;
    cyc("resume");
    check("resume_q0", 32'(q[0]), START + 1);

    // Saturation up.
    mode = 2'd0; lim = 8'd10; step = 8'd3;
    set0(0, 1, 1, 0); rnd_others(); cyc("sat_ld");
    for (int k = 0; k < 5; k++) begin
      set0(1, 1, 0, 0); rnd_others(); cyc("sat");
      check("sat_q0", 32'(q[0]), sat_q[k]);
      check("sat_evt0", 32'(evt[0]), sat_e[k]);
    end
    #1;
    check("sat_at_lim0", 32'(at_lim[0]), 1);

    // Roll down.
    mode = 2'd1; lim = 8'd10; step = 8'd4;
    set0(0, 0, 1, 5); rnd_others(); cyc("roll_ld");
    for (int k = 0; k < 5; k++) begin
      set0(1, 0, 0, 0); rnd_others(); cyc("roll");
      check("roll_q0", 32'(q[0]), roll_q[k]);
      check("roll_evt0", 32'(evt[0]), roll_e[k]);
    end

    // Bounce, dir input randomised and ignored.
    srst = 1'b1; cyc("srst");
    srst = 1'b0;
    mode = 2'd2; lim = 8'd5; step = 8'd2;
    set0(0, 1, 1, 0); rnd_others(); cyc("bnc_ld");
    for (int k = 0; k < 7; k++) begin
      set0(1, 1'($urandom), 0, 0); rnd_others(); cyc("bnc");
      check("bnc_q0", 32'(q[0]), bnc_q[k]);
      check("bnc_evt0", 32'(evt[0]), bnc_e[k]);
    end

    // Bounce reversal from a channel already at the limit.
    step = 8'd1;
    set0(0, 1, 1, 4); rnd_others(); cyc("rev_ld");
    for (int k = 0; k < 3; k++) begin
      set0(1, 1'($urandom), 0, 0); rnd_others(); cyc("rev");
      check("rev_q0", 32'(q[0]), rev_q[k]);
      check("rev_evt0", 32'(evt[0]), rev_e[k]);
    end

    // Priority srst > load > ena, unclamped load then saturation.
    mode = 2'd0; step = 8'd1; lim = 8'd100;
    srst = 1'b1; set0(1, 1, 1, 9); rnd_others(); cyc("prio_srst");
    check("prio_srst_q0", 32'(q[0]), START);
    srst = 1'b0; set0(1, 1, 1, 200); rnd_others(); cyc("prio_load");
    check("prio_load_q0", 32'(q[0]), 200);
    set0(1, 1, 0, 0); rnd_others(); cyc("prio_sat");
    check("prio_sat_q0", 32'(q[0]), 100);
    check("prio_sat_evt0", 32'(evt[0]), 1);

    // step=0 with lim lowered below q.
    step = 8'd0; lim = 8'd20;
    set0(0, 1, 1, 50); rnd_others(); cyc("s0_ld");
    set0(1, 1, 0, 0); rnd_others(); cyc("s0_sat");
    check("s0_sat_q0", 32'(q[0]), 20);
    check("s0_sat_evt0", 32'(evt[0]), 1);
    set0(1, 1, 0, 0); rnd_others(); cyc("s0_hold");
    check("s0_hold_evt0", 32'(evt[0]), 0);
    mode = 2'd1;
    set0(0, 1, 1, 50); rnd_others(); cyc("s0r_ld");
    set0(1, 1, 0, 0); rnd_others(); cyc("s0_roll");
    check("s0_roll_q0", 32'(q[0]), 0);

    // Fully random traffic, all modes including the reserved one.
    for (int k = 0; k < 400; k++) begin
      mode = 2'($urandom);
      step = ($urandom_range(3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(4));
      if ($urandom_range(7) == 0)
        lim = ($urandom_range(1) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(12));
      srst = ($urandom_range(60) == 0);
      for (int i = 0; i < CH; i++) begin
        ena[i]      = ($urandom_range(3) != 0);
        dir[i]      = 1'($urandom);
        load[i]     = ($urandom_range(9) == 0);
        load_val[i] = WIDTH'($urandom_range(15));
      end
      cyc("rand");
    end
    srst = 1'b0;

`ifdef BCNT_BANK_CASCADE_EN
    mode = 2'd1; lim = 8'd9; step = 8'd1; dir = '1; ena = '1;
    load = '1; load_val = '0; cyc("casc_ld");
    load = '0;
    for (int k = 0; k < 100; k++) cyc("casc");
    check("casc_q0", 32'(q[0]), 0);
    check("casc_q1", 32'(q[1]), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
